// File: rtl/redirect_gen.sv
// redirect_gen: turns resolved branches that miss the fall-through prediction into a held redirect plus flush pulse.
// Optional `REDIRECT_CNT_EN adds the saturating mispred_cnt output.
module redirect_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_valid,
   input  logic [63:0] br_pc,
   input  logic        br_taken,
   input  logic [63:0] br_target,
   output logic        br_ready,
   output logic        redirect_valid,
   output logic [63:0] redirect_target,
   input  logic        redirect_ready,
   output logic        flush,
   output logic        misalign_err
`ifdef REDIRECT_CNT_EN
   ,
   output logic [63:0] mispred_cnt
`endif
);
   typedef enum logic {IDLE, PENDING} state_e;
   state_e      state_q, state_d;
   logic [63:0] target_q, target_d, fall_thru, actual;
   logic        flush_q, flush_d, misalign_q, misalign_d;
   logic        accept, misalign, mispred;
   assign fall_thru = br_pc + 64'd4;
   assign actual    = br_taken ? br_target : fall_thru;
   assign accept    = br_valid && state_q == IDLE;
   assign misalign  = br_taken && br_target[1:0] != 2'b00;
   // a not-taken branch always matches the fall-through, so only aligned taken targets can redirect
   assign mispred   = accept && !misalign && actual != fall_thru;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         target_q   <= '0;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
      end
   end
   always_comb begin
      state_d    = state_q == IDLE ? (mispred ? PENDING : IDLE) : (redirect_ready ? IDLE : PENDING);
      target_d   = mispred ? actual : target_q;
      flush_d    = mispred;
      misalign_d = accept && misalign;
   end
   always_comb begin
      br_ready        = state_q == IDLE;
      redirect_valid  = state_q == PENDING;
      redirect_target = target_q;
      flush           = flush_q;
      misalign_err    = misalign_q;
   end
`ifdef REDIRECT_CNT_EN
   logic [63:0] cnt_q, cnt_d;
   assign cnt_d = mispred && ~&cnt_q ? cnt_q + 64'd1 : cnt_q;
   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign mispred_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_redirect_gen.sv
// tb_redirect_gen: directed checks of redirect_gen handshakes, flush/misalign pulses, wrap and reset.
module tb_redirect_gen;
   logic        clk = 1'b0;
   logic        rst, br_valid, br_taken, redirect_ready;
   logic [63:0] br_pc, br_target;
   logic        br_ready, redirect_valid, flush, misalign_err;
   logic [63:0] redirect_target;
`ifdef REDIRECT_CNT_EN
   logic [63:0] mispred_cnt;
`endif
   int tests = 0;
   int fails = 0;

   redirect_gen dut (
      .clk(clk),
      .rst(rst),
      .br_valid(br_valid),
      .br_pc(br_pc),
      .br_taken(br_taken),
      .br_target(br_target),
      .br_ready(br_ready),
      .redirect_valid(redirect_valid),
      .redirect_target(redirect_target),
      .redirect_ready(redirect_ready),
      .flush(flush),
      .misalign_err(misalign_err)
`ifdef REDIRECT_CNT_EN
      ,
      .mispred_cnt(mispred_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [63:0] exp);
`ifdef REDIRECT_CNT_EN
      chk(tag, mispred_cnt, exp);
`endif
   endtask

   initial begin
      rst = 1'b0; br_valid = 1'b0; br_taken = 1'b0; redirect_ready = 1'b0;
      br_pc = '0; br_target = '0;
      tick(); tick();
      chk("rst_br_ready", br_ready, 1);
      chk("rst_rv", redirect_valid, 0);
      chk("rst_target", redirect_target, 0);
      chk("rst_flush", flush, 0);
      chk("rst_misalign", misalign_err, 0);
      chk_cnt("rst_cnt", 0);
      rst = 1'b1;
      // not taken: fall-through matches prediction
      br_valid = 1'b1; br_pc = 64'h8000_0000; br_taken = 1'b0;
      tick();
      br_valid = 1'b0;
      chk("nt_rv", redirect_valid, 0);
      chk("nt_flush", flush, 0);
      chk("nt_br_ready", br_ready, 1);
      chk("nt_misalign", misalign_err, 0);
      // taken mispredict, redirect_ready low for 3 cycles; br_valid kept high to show it is ignored
      br_valid = 1'b1; br_taken = 1'b1; br_target = 64'h8000_0100;
      tick();
      br_target = 64'h2000;
      chk("mp1_rv", redirect_valid, 1);
      chk("mp1_flush", flush, 1);
      chk("mp1_target", redirect_target, 64'h8000_0100);
      chk("mp1_br_ready", br_ready, 0);
      chk_cnt("mp1_cnt", 1);
      tick();
      chk("mp2_rv", redirect_valid, 1);
      chk("mp2_flush", flush, 0);
      chk("mp2_br_ready", br_ready, 0);
      tick();
      chk("mp3_rv", redirect_valid, 1);
      chk("mp3_flush", flush, 0);
      chk("mp3_target", redirect_target, 64'h8000_0100);
      tick();
      chk("mp4_rv", redirect_valid, 1);
      chk("mp4_flush", flush, 0);
      chk("mp4_br_ready", br_ready, 0);
      chk("mp4_target", redirect_target, 64'h8000_0100);
      redirect_ready = 1'b1; br_valid = 1'b0;
      tick();
      redirect_ready = 1'b0;
      chk("hs_rv", redirect_valid, 0);
      chk("hs_br_ready", br_ready, 1);
      chk("hs_flush", flush, 0);
      chk("hs_target_held", redirect_target, 64'h8000_0100);
      chk_cnt("hs_cnt", 1);
      // taken to pc+4 is not a mispredict
      br_valid = 1'b1; br_pc = 64'h8000_0000; br_taken = 1'b1; br_target = 64'h8000_0004;
      tick();
      chk("t4_rv", redirect_valid, 0);
      chk("t4_flush", flush, 0);
      chk("t4_misalign", misalign_err, 0);
      br_target = 64'h8000_0102;
      tick();
      br_valid = 1'b0;
      chk("mis_pulse", misalign_err, 1);
      chk("mis_rv", redirect_valid, 0);
      chk("mis_flush", flush, 0);
      tick();
      chk("mis_once", misalign_err, 0);
      chk("mis_br_ready", br_ready, 1);
      // fall-through wraps to 0
      br_valid = 1'b1; br_pc = 64'hFFFF_FFFF_FFFF_FFFC; br_taken = 1'b0;
      tick();
      chk("wrap_nt_rv", redirect_valid, 0);
      chk("wrap_nt_flush", flush, 0);
      br_taken = 1'b1; br_target = 64'h0;
      tick();
      br_valid = 1'b0;
      chk("wrap_t0_rv", redirect_valid, 0);
      chk("wrap_t0_flush", flush, 0);
      chk_cnt("wrap_cnt", 1);
      // reset while pending drops the redirect
      br_valid = 1'b1; br_pc = 64'h0; br_taken = 1'b1; br_target = 64'h1000;
      tick();
      br_valid = 1'b0;
      chk("pr_rv", redirect_valid, 1);
      chk("pr_target", redirect_target, 64'h1000);
      chk("pr_flush", flush, 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("pr_rst_rv", redirect_valid, 0);
      chk("pr_rst_br_ready", br_ready, 1);
      chk("pr_rst_target", redirect_target, 0);
      chk("pr_rst_flush", flush, 0);
      chk_cnt("pr_rst_cnt", 0);
      tick();
      chk("post_rst_br_ready", br_ready, 1);
      chk("post_rst_rv", redirect_valid, 0);
      br_valid = 1'b1; br_pc = 64'h40; br_taken = 1'b1; br_target = 64'h80;
      tick();
      br_valid = 1'b0; redirect_ready = 1'b1;
      chk("again_rv", redirect_valid, 1);
      chk("again_target", redirect_target, 64'h80);
      chk("again_flush", flush, 1);
      chk_cnt("again_cnt", 1);
      tick();
      redirect_ready = 1'b0;
      chk("again_hs_rv", redirect_valid, 0);
      chk("again_hs_br_ready", br_ready, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
